// File: rtl/uart_sys_ctrl_if.sv
// ---------------------------------------------------------------------------
// uart_sys_ctrl_if
//   Bundle of every signal exchanged between the UART command controller and
//   the surrounding system (UART RX datapath, register file, ALU, TX FIFO).
//
//   Signals (controller view, modport master):
//     RX_P_DATA    in   DATA_WIDTH    received byte
//     RX_D_VLD     in   1             one-cycle strobe, RX_P_DATA valid
//     RdData       in   DATA_WIDTH    register-file read data
//     RdData_Valid in   1             one-cycle strobe, RdData valid
//     ALU_OUT      in   2*DATA_WIDTH  ALU result
//     ALU_OUT_VLD  in   1             one-cycle strobe, ALU_OUT valid
//     FIFO_FULL    in   1             TX FIFO full
//     Address      out  ADDR_WIDTH    register-file address
//     WrEn         out  1             register-file write strobe
//     RdEn         out  1             register-file read strobe
//     WrData       out  DATA_WIDTH    register-file write data
//     ALU_EN       out  1             ALU start strobe
//     ALU_FUN      out  4             ALU function select
//     CLK_EN       out  1             ALU clock-gate enable
//     TX_P_DATA    out  DATA_WIDTH    byte to TX FIFO
//     TX_D_VLD     out  1             TX FIFO write strobe
//
//   modport master : the controller
//   modport slave  : the system side that drives the controller's inputs
// ---------------------------------------------------------------------------
interface uart_sys_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);

  // UART receive side
  logic [DATA_WIDTH-1:0]   RX_P_DATA;
  logic                    RX_D_VLD;

  // register file
  logic [DATA_WIDTH-1:0]   RdData;
  logic                    RdData_Valid;
  logic [ADDR_WIDTH-1:0]   Address;
  logic                    WrEn;
  logic                    RdEn;
  logic [DATA_WIDTH-1:0]   WrData;

  // ALU
  logic [2*DATA_WIDTH-1:0] ALU_OUT;
  logic                    ALU_OUT_VLD;
  logic                    ALU_EN;
  logic [3:0]              ALU_FUN;
  logic                    CLK_EN;

  // TX FIFO
  logic                    FIFO_FULL;
  logic [DATA_WIDTH-1:0]   TX_P_DATA;
  logic                    TX_D_VLD;

  modport master (
    input  RX_P_DATA, RX_D_VLD,
    input  RdData, RdData_Valid,
    input  ALU_OUT, ALU_OUT_VLD,
    input  FIFO_FULL,
    output Address, WrEn, RdEn, WrData,
    output ALU_EN, ALU_FUN, CLK_EN,
    output TX_P_DATA, TX_D_VLD
  );

  modport slave (
    output RX_P_DATA, RX_D_VLD,
    output RdData, RdData_Valid,
    output ALU_OUT, ALU_OUT_VLD,
    output FIFO_FULL,
    input  Address, WrEn, RdEn, WrData,
    input  ALU_EN, ALU_FUN, CLK_EN,
    input  TX_P_DATA, TX_D_VLD
  );

endinterface

// File: rtl/uart_sys_ctrl.sv
// ---------------------------------------------------------------------------
// uart_sys_ctrl
//   Command controller between the UART byte stream and the system core.
//   Parses opcode frames, sequences register-file writes/reads and ALU runs,
//   and streams results back to the TX FIFO.
//
//   Frames (first byte is the opcode):
//     CMD_WR      : opcode, addr, data      -> register write
//     CMD_RD      : opcode, addr            -> register read, 1 result byte
//     CMD_ALU_OP  : opcode, A, B, fun       -> write A/B to regs 0/1, run ALU,
//                                              2 result bytes (lo then hi)
//     CMD_ALU_NOP : opcode, fun             -> run ALU on stored operands
//
//   Ports:
//     CLK  in  system clock
//     RST  in  asynchronous, active-low reset
//     bus  uart_sys_ctrl_if.master (see interface file for the signal list)
// ---------------------------------------------------------------------------
module uart_sys_ctrl #(
  parameter int                    DATA_WIDTH  = 8,
  parameter int                    ADDR_WIDTH  = 4,
  parameter logic [DATA_WIDTH-1:0] CMD_WR      = 8'hAA,
  parameter logic [DATA_WIDTH-1:0] CMD_RD      = 8'hBB,
  parameter logic [DATA_WIDTH-1:0] CMD_ALU_OP  = 8'hCC,
  parameter logic [DATA_WIDTH-1:0] CMD_ALU_NOP = 8'hDD
) (
  input  logic            CLK,
  input  logic            RST,
  uart_sys_ctrl_if.master bus
);

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    WR_ADDR  = 4'd1,
    WR_DATA  = 4'd2,
    RD_ADDR  = 4'd3,
    RD_WAIT  = 4'd4,
    OP_A     = 4'd5,
    OP_B     = 4'd6,
    FUN      = 4'd7,
    ALU_WAIT = 4'd8,
    TX_LO    = 4'd9,
    TX_HI    = 4'd10
  } state_t;

  // ALU operands live at fixed register-file locations
  localparam logic [ADDR_WIDTH-1:0] OPA_ADDR = ADDR_WIDTH'(0);
  localparam logic [ADDR_WIDTH-1:0] OPB_ADDR = ADDR_WIDTH'(1);

  state_t                  r_state;
  state_t                  w_state_next;

  logic [ADDR_WIDTH-1:0]   r_address,  w_address_next;
  logic [DATA_WIDTH-1:0]   r_wr_data,  w_wr_data_next;
  logic                    r_wr_en,    w_wr_en_next;
  logic                    r_rd_en,    w_rd_en_next;
  logic                    r_alu_en,   w_alu_en_next;
  logic [3:0]              r_alu_fun,  w_alu_fun_next;
  logic                    r_clk_en,   w_clk_en_next;
  logic [2*DATA_WIDTH-1:0] r_result,   w_result_next;
  logic [DATA_WIDTH-1:0]   r_tx_data,  w_tx_data_next;

  logic                    w_tx_state;
  logic                    w_tx_fire;

  // A TX byte is accepted only when the FIFO has room; the FSM uses the same
  // condition to advance so a stalled byte is neither lost nor repeated.
  assign w_tx_state = (r_state == TX_LO) || (r_state == TX_HI);
  assign w_tx_fire  = w_tx_state && !bus.FIFO_FULL;

  // -------------------------------------------------------------------------
  // State and output registers
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state   <= IDLE;
      r_address <= '0;
      r_wr_data <= '0;
      r_wr_en   <= 1'b0;
      r_rd_en   <= 1'b0;
      r_alu_en  <= 1'b0;
      r_alu_fun <= '0;
      r_clk_en  <= 1'b0;
      r_result  <= '0;
      r_tx_data <= '0;
    end else begin
      r_state   <= w_state_next;
      r_address <= w_address_next;
      r_wr_data <= w_wr_data_next;
      r_wr_en   <= w_wr_en_next;
      r_rd_en   <= w_rd_en_next;
      r_alu_en  <= w_alu_en_next;
      r_alu_fun <= w_alu_fun_next;
      r_clk_en  <= w_clk_en_next;
      r_result  <= w_result_next;
      r_tx_data <= w_tx_data_next;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic. Each state looks only at the one strobe it cares
  // about; bytes arriving while waiting on the core or on the FIFO fall
  // through untouched.
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (bus.RX_D_VLD) begin
          if (bus.RX_P_DATA == CMD_WR)           w_state_next = WR_ADDR;
          else if (bus.RX_P_DATA == CMD_RD)      w_state_next = RD_ADDR;
          else if (bus.RX_P_DATA == CMD_ALU_OP)  w_state_next = OP_A;
          else if (bus.RX_P_DATA == CMD_ALU_NOP) w_state_next = FUN;
          else                                   w_state_next = IDLE;
        end
      end
      WR_ADDR:  if (bus.RX_D_VLD)     w_state_next = WR_DATA;
      WR_DATA:  if (bus.RX_D_VLD)     w_state_next = IDLE;
      RD_ADDR:  if (bus.RX_D_VLD)     w_state_next = RD_WAIT;
      // a read returns a single byte, so it skips straight to the last TX state
      RD_WAIT:  if (bus.RdData_Valid) w_state_next = TX_HI;
      OP_A:     if (bus.RX_D_VLD)     w_state_next = OP_B;
      OP_B:     if (bus.RX_D_VLD)     w_state_next = FUN;
      FUN:      if (bus.RX_D_VLD)     w_state_next = ALU_WAIT;
      ALU_WAIT: if (bus.ALU_OUT_VLD)  w_state_next = TX_LO;
      TX_LO:    if (w_tx_fire)        w_state_next = TX_HI;
      TX_HI:    if (w_tx_fire)        w_state_next = IDLE;
      default:                        w_state_next = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Output logic. Strobes default low so each lasts exactly one cycle;
  // address, data, function select and result hold until overwritten.
  // -------------------------------------------------------------------------
  always_comb begin
    w_address_next = r_address;
    w_wr_data_next = r_wr_data;
    w_wr_en_next   = 1'b0;
    w_rd_en_next   = 1'b0;
    w_alu_en_next  = 1'b0;
    w_alu_fun_next = r_alu_fun;
    w_clk_en_next  = r_clk_en;
    w_result_next  = r_result;
    w_tx_data_next = r_tx_data;
    unique case (r_state)
      WR_ADDR: begin
        if (bus.RX_D_VLD) w_address_next = bus.RX_P_DATA[ADDR_WIDTH-1:0];
      end
      WR_DATA: begin
        if (bus.RX_D_VLD) begin
          w_wr_data_next = bus.RX_P_DATA;
          w_wr_en_next   = 1'b1;
        end
      end
      RD_ADDR: begin
        if (bus.RX_D_VLD) begin
          w_address_next = bus.RX_P_DATA[ADDR_WIDTH-1:0];
          w_rd_en_next   = 1'b1;
        end
      end
      RD_WAIT: begin
        if (bus.RdData_Valid) begin
          w_result_next[DATA_WIDTH-1:0] = bus.RdData;
          // TX data is preloaded so it is already stable in the TX state
          w_tx_data_next                = bus.RdData;
        end
      end
      OP_A: begin
        if (bus.RX_D_VLD) begin
          w_address_next = OPA_ADDR;
          w_wr_data_next = bus.RX_P_DATA;
          w_wr_en_next   = 1'b1;
        end
      end
      OP_B: begin
        if (bus.RX_D_VLD) begin
          w_address_next = OPB_ADDR;
          w_wr_data_next = bus.RX_P_DATA;
          w_wr_en_next   = 1'b1;
        end
      end
      FUN: begin
        if (bus.RX_D_VLD) begin
          w_alu_fun_next = bus.RX_P_DATA[3:0];
          w_alu_en_next  = 1'b1;
          // ALU clock must be running in the same cycle as its start strobe
          w_clk_en_next  = 1'b1;
        end
      end
      ALU_WAIT: begin
        if (bus.ALU_OUT_VLD) begin
          w_result_next  = bus.ALU_OUT;
          w_tx_data_next = bus.ALU_OUT[DATA_WIDTH-1:0];
          w_clk_en_next  = 1'b0;
        end
      end
      TX_LO: begin
        // low byte goes out this cycle; line up the high byte for TX_HI
        if (w_tx_fire) w_tx_data_next = r_result[2*DATA_WIDTH-1:DATA_WIDTH];
      end
      default: begin
      end
    endcase
  end

  assign bus.Address   = r_address;
  assign bus.WrData    = r_wr_data;
  assign bus.WrEn      = r_wr_en;
  assign bus.RdEn      = r_rd_en;
  assign bus.ALU_EN    = r_alu_en;
  assign bus.ALU_FUN   = r_alu_fun;
  assign bus.CLK_EN    = r_clk_en;
  assign bus.TX_P_DATA = r_tx_data;
  assign bus.TX_D_VLD  = w_tx_fire;

endmodule

// File: tb/tb_uart_sys_ctrl.sv
`timescale 1ns/1ps
module tb_uart_sys_ctrl;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  int   cyc = 0;

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  uart_sys_ctrl_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) bus ();

  uart_sys_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference register contents as the commands say they should be
  logic [7:0] model_rf [16];

  // External register file as actually written by the controller
  logic [7:0] env_rf [16] = '{default: 8'h00};

  // Observed events, sampled on the falling edge
  logic [3:0] wr_addr_q [$];
  logic [7:0] wr_data_q [$];
  int         wr_cyc_q  [$];
  logic [3:0] rd_addr_q [$];
  int         rd_cyc_q  [$];
  logic [3:0] alu_fun_q [$];
  logic       alu_cke_q [$];
  int         alu_cyc_q [$];
  logic [7:0] tx_q      [$];
  int         tx_cyc_q  [$];

  always @(negedge CLK) begin
    if (bus.WrEn) begin
      wr_addr_q.push_back(bus.Address);
      wr_data_q.push_back(bus.WrData);
      wr_cyc_q.push_back(cyc);
      env_rf[bus.Address] <= bus.WrData;
    end
    if (bus.RdEn) begin
      rd_addr_q.push_back(bus.Address);
      rd_cyc_q.push_back(cyc);
    end
    if (bus.ALU_EN) begin
      alu_fun_q.push_back(bus.ALU_FUN);
      alu_cke_q.push_back(bus.CLK_EN);
      alu_cyc_q.push_back(cyc);
    end
    if (bus.TX_D_VLD) begin
      tx_q.push_back(bus.TX_P_DATA);
      tx_cyc_q.push_back(cyc);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                            input logic [3:0] f);
    case (f)
      4'd0:    return 16'(a) + 16'(b);
      4'd1:    return 16'(a) - 16'(b);
      4'd2:    return 16'(a) * 16'(b);
      4'd3:    return {8'h00, a & b};
      4'd4:    return {8'h00, a | b};
      default: return {8'h00, a ^ b};
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // Presents one byte for one cycle followed by one idle cycle.
  task automatic send_byte(input logic [7:0] b, output int scyc);
    bus.RX_P_DATA = b;
    bus.RX_D_VLD  = 1'b1;
    scyc = cyc;
    tick(1);
    bus.RX_D_VLD  = 1'b0;
    tick(1);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_addr"},   32'(bus.Address),   32'h0);
    check({tag, "_wrdata"}, 32'(bus.WrData),    32'h0);
    check({tag, "_wren"},   32'(bus.WrEn),      32'h0);
    check({tag, "_rden"},   32'(bus.RdEn),      32'h0);
    check({tag, "_aluen"},  32'(bus.ALU_EN),    32'h0);
    check({tag, "_alufun"}, 32'(bus.ALU_FUN),   32'h0);
    check({tag, "_clken"},  32'(bus.CLK_EN),    32'h0);
    check({tag, "_txdata"}, 32'(bus.TX_P_DATA), 32'h0);
    check({tag, "_txvld"},  32'(bus.TX_D_VLD),  32'h0);
  endtask

  task automatic do_write(input logic [7:0] abyte, input logic [7:0] d);
    int s, wb, tb0;
    wb  = wr_addr_q.size();
    tb0 = tx_q.size();
    send_byte(8'hAA, s);
    send_byte(abyte, s);
    send_byte(d, s);
    tick(2);
    check("wr_count", 32'(wr_addr_q.size() - wb), 32'd1);
    if (wr_addr_q.size() > wb) begin
      check("wr_addr", 32'(wr_addr_q[wb]), 32'(abyte[3:0]));
      check("wr_data", 32'(wr_data_q[wb]), 32'(d));
      check("wr_lat",  32'(wr_cyc_q[wb]),  32'(s + 1));
    end
    check("wr_no_tx", 32'(tx_q.size() - tb0), 32'd0);
    model_rf[abyte[3:0]] = d;
    $display("WRITE addr=%0h data=%02h", abyte[3:0], d);
  endtask

  task automatic do_read(input logic [7:0] abyte, input int stall);
    int s, rb, tb0, v;
    logic [7:0] exp_b;
    rb    = rd_addr_q.size();
    tb0   = tx_q.size();
    exp_b = model_rf[abyte[3:0]];
    send_byte(8'hBB, s);
    send_byte(abyte, s);
    check("rd_count", 32'(rd_addr_q.size() - rb), 32'd1);
    if (rd_addr_q.size() > rb) begin
      check("rd_addr", 32'(rd_addr_q[rb]), 32'(abyte[3:0]));
      check("rd_lat",  32'(rd_cyc_q[rb]),  32'(s + 1));
    end
    bus.FIFO_FULL    = (stall > 0);
    bus.RdData       = env_rf[bus.Address];
    bus.RdData_Valid = 1'b1;
    v = cyc;
    tick(1);
    bus.RdData_Valid = 1'b0;
    if (stall > 0) begin
      tick(stall);
      check("rd_tx_while_full", 32'(tx_q.size() - tb0), 32'd0);
      bus.FIFO_FULL = 1'b0;
    end
    for (int k = 0; k < 30 && tx_q.size() < tb0 + 1; k++) tick(1);
    tick(3);
    check("rd_tx_count", 32'(tx_q.size() - tb0), 32'd1);
    if (tx_q.size() > tb0) begin
      check("rd_tx_data", 32'(tx_q[tb0]), 32'(exp_b));
      if (stall == 0) check("rd_tx_lat", 32'(tx_cyc_q[tb0]), 32'(v + 1));
    end
    $display("READ  addr=%0h expect=%02h stall=%0d", abyte[3:0], exp_b, stall);
  endtask

  task automatic do_alu(input bit is_cc, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] fun, input bit forced, input logic [15:0] fval,
                        input int stall, input bit inject_aa);
    int s, s2, wb, ab, rb, tb0, m;
    logic [15:0] exp_r;
    wb  = wr_addr_q.size();
    ab  = alu_fun_q.size();
    rb  = rd_addr_q.size();
    tb0 = tx_q.size();
    if (is_cc) begin
      send_byte(8'hCC, s);
      send_byte(a, s);
      send_byte(b, s);
      model_rf[0] = a;
      model_rf[1] = b;
    end else begin
      send_byte(8'hDD, s);
    end
    send_byte(fun, s);
    exp_r = forced ? fval : alu_model(model_rf[0], model_rf[1], fun[3:0]);
    if (is_cc) begin
      check("op_wr_count", 32'(wr_addr_q.size() - wb), 32'd2);
      if (wr_addr_q.size() >= wb + 2) begin
        check("opa_addr", 32'(wr_addr_q[wb]),     32'h0);
        check("opa_data", 32'(wr_data_q[wb]),     32'(a));
        check("opb_addr", 32'(wr_addr_q[wb + 1]), 32'h1);
        check("opb_data", 32'(wr_data_q[wb + 1]), 32'(b));
      end
    end
    check("aluen_count", 32'(alu_fun_q.size() - ab), 32'd1);
    if (alu_fun_q.size() > ab) begin
      check("alu_fun",      32'(alu_fun_q[ab]), 32'(fun[3:0]));
      check("clken_at_en",  32'(alu_cke_q[ab]), 32'd1);
      check("aluen_lat",    32'(alu_cyc_q[ab]), 32'(s + 1));
    end
    if (inject_aa) send_byte(8'hAA, s2);
    tick($urandom_range(0, 3));
    check("clken_wait", 32'(bus.CLK_EN), 32'd1);
    bus.FIFO_FULL   = (stall > 0);
    bus.ALU_OUT     = exp_r;
    bus.ALU_OUT_VLD = 1'b1;
    m = cyc;
    tick(1);
    bus.ALU_OUT_VLD = 1'b0;
    check("clken_fall", 32'(bus.CLK_EN), 32'd0);
    if (stall > 0) begin
      tick(stall);
      check("alu_tx_while_full", 32'(tx_q.size() - tb0), 32'd0);
      bus.FIFO_FULL = 1'b0;
    end
    for (int k = 0; k < 30 && tx_q.size() < tb0 + 2; k++) tick(1);
    tick(3);
    check("alu_tx_count", 32'(tx_q.size() - tb0), 32'd2);
    if (tx_q.size() >= tb0 + 2) begin
      check("alu_tx_lo", 32'(tx_q[tb0]),     32'(exp_r[7:0]));
      check("alu_tx_hi", 32'(tx_q[tb0 + 1]), 32'(exp_r[15:8]));
      if (stall == 0) begin
        check("alu_tx_lo_lat", 32'(tx_cyc_q[tb0]),     32'(m + 1));
        check("alu_tx_hi_lat", 32'(tx_cyc_q[tb0 + 1]), 32'(m + 2));
      end
    end
    check("alu_wr_total", 32'(wr_addr_q.size() - wb), is_cc ? 32'd2 : 32'd0);
    check("alu_rd_total", 32'(rd_addr_q.size() - rb), 32'd0);
    check("clken_after",  32'(bus.CLK_EN), 32'd0);
    $display("ALU   %s fun=%0h result=%04h stall=%0d inject=%0d",
             is_cc ? "CC" : "DD", fun[3:0], exp_r, stall, inject_aa);
  endtask

  initial begin
    int s, wb, rb, ab, tb0;
    int op;
    for (int i = 0; i < 16; i++) model_rf[i] = 8'h00;
    bus.RX_P_DATA    = '0;
    bus.RX_D_VLD     = 1'b0;
    bus.RdData       = '0;
    bus.RdData_Valid = 1'b0;
    bus.ALU_OUT      = '0;
    bus.ALU_OUT_VLD  = 1'b0;
    bus.FIFO_FULL    = 1'b0;

    // Reset state
    tick(3);
    check_outputs_zero("reset");
    RST = 1'b1;
    tick(2);
    check_outputs_zero("post_reset");
    $display("RESET released");

    // Register write
    do_write(8'h05, 8'h3C);

    // Register read
    do_write(8'h02, 8'h7E);
    do_read(8'h02, 0);

    // ALU with operands: 10 + 20
    do_alu(1'b1, 8'h10, 8'h20, 8'h00, 1'b0, 16'h0, 0, 1'b0);

    // Backpressure on stored-operand ALU command
    do_alu(1'b0, 8'h00, 8'h00, 8'h02, 1'b1, 16'h1234, 10, 1'b0);

    // Illegal opcode in IDLE
    wb  = wr_addr_q.size();
    rb  = rd_addr_q.size();
    ab  = alu_fun_q.size();
    tb0 = tx_q.size();
    send_byte(8'h55, s);
    tick(3);
    check("illegal_activity",
          32'((wr_addr_q.size() - wb) + (rd_addr_q.size() - rb) +
              (alu_fun_q.size() - ab) + (tx_q.size() - tb0)), 32'd0);
    $display("ILLEGAL byte 55 sent");

    // Opcode byte during ALU_WAIT is dropped, then a normal write follows
    do_alu(1'b1, 8'h07, 8'h03, 8'h01, 1'b0, 16'h0, 0, 1'b1);
    do_write(8'h01, 8'hFF);

    // Reset mid-command
    send_byte(8'hCC, s);
    send_byte(8'h11, s);
    model_rf[0] = 8'h11;
    check("pre_rst_wrdata", 32'(bus.WrData), 32'h11);
    #2;
    RST = 1'b0;
    #1;
    check_outputs_zero("mid_reset");
    @(posedge CLK);
    #1;
    RST = 1'b1;
    tick(1);
    $display("RESET mid-command");
    do_write(8'h03, 8'h09);

    // Randomized command mix
    for (int n = 0; n < 24; n++) begin
      op = $urandom_range(0, 3);
      case (op)
        0: do_write(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
        1: do_read(8'($urandom_range(0, 255)), $urandom_range(0, 4));
        2: do_alu(1'b1, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                  8'($urandom_range(0, 255)), 1'b0, 16'h0, $urandom_range(0, 4),
                  1'($urandom_range(0, 1)));
        default: do_alu(1'b0, 8'h00, 8'h00, 8'($urandom_range(0, 255)), 1'b0, 16'h0,
                        $urandom_range(0, 4), 1'b0);
      endcase
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
